// File: rtl/axi_rd_pkg.sv
// Shared constants for the AXI read-slave memory block.
//   - Burst type codes carried on ARBURST
//   - Response codes driven on RRESP
//   - Responder FSM state encoding
package axi_rd_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

endpackage

// File: rtl/axi_rd_addr_gen.sv
// Combinational next-beat address for an AXI read burst.
// Ports:
//   addr      in   current beat byte address
//   len       in   ARLEN (beats minus one)
//   size      in   ARSIZE (bytes per beat = 2^size, clamped to the data width)
//   burst     in   ARBURST
//   next_addr out  byte address of the following beat
// FIXED holds the address; WRAP wraps inside a (len+1)*step window only for
// len+1 in {2,4,8,16}; every other case (incl. reserved type) increments.
module axi_rd_addr_gen
   import axi_rd_pkg::*;
#(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int ARLEN_WIDTH   = 4,
   parameter int ARSIZE_WIDTH  = 3,
   parameter int ARBURST_WIDTH = 2
) (
   input  logic [ADDR_WIDTH-1:0]    addr,
   input  logic [ARLEN_WIDTH-1:0]   len,
   input  logic [ARSIZE_WIDTH-1:0]  size,
   input  logic [ARBURST_WIDTH-1:0] burst,
   output logic [ADDR_WIDTH-1:0]    next_addr
);

   localparam int SZ_MAX = $clog2(DATA_WIDTH / 8);

   logic [ARSIZE_WIDTH-1:0] size_c;
   logic [ADDR_WIDTH-1:0]   step, len_p1, mask;
   logic                    wrap_ok;

   always_comb begin
      size_c  = (int'(size) > SZ_MAX) ? ARSIZE_WIDTH'(SZ_MAX) : size;
      step    = ADDR_WIDTH'(1) << size_c;
      len_p1  = ADDR_WIDTH'(len) + ADDR_WIDTH'(1);
      // wrap window is (len+1)*step bytes, always a power of two when legal
      mask    = (len_p1 << size_c) - ADDR_WIDTH'(1);
      wrap_ok = (len_p1 == ADDR_WIDTH'(2)) || (len_p1 == ADDR_WIDTH'(4)) ||
                (len_p1 == ADDR_WIDTH'(8)) || (len_p1 == ADDR_WIDTH'(16));
      next_addr = addr + step;
      if (burst == ARBURST_WIDTH'(BURST_FIXED))
         next_addr = addr;
      else if (burst == ARBURST_WIDTH'(BURST_WRAP) && wrap_ok)
         next_addr = (addr & ~mask) | ((addr + step) & mask);
   end

endmodule

// File: rtl/axi_read_slave_mem.sv
// AXI read-channel slave backed by an on-chip word memory.
// Ports:
//   ACLK, ARESETN                  clock / async active-low reset
//   S_AR*                          read address channel (slave side)
//   S_R*                           read data channel (slave side)
//   mem_wr_en/addr/data            synchronous preload port (word indexed)
// Build option: define AXI_RD_SLV_ERR_EN to answer out-of-range beats and
// reserved bursts with SLVERR; otherwise every beat is OKAY.
// Beat data is read from memory at the edge the beat is launched, so the
// read is effectively registered and a preload write that has already
// landed is visible.
module axi_read_slave_mem
   import axi_rd_pkg::*;
#(
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int ARLEN_WIDTH   = 4,
   parameter int ARSIZE_WIDTH  = 3,
   parameter int ARBURST_WIDTH = 2,
   parameter int RRESP_WIDTH   = 2,
   parameter int MEM_DEPTH     = 256,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                         ACLK,
   input  logic                         ARESETN,
   input  logic [ADDR_WIDTH-1:0]        S_ARADDR,
   input  logic [ARLEN_WIDTH-1:0]       S_ARLEN,
   input  logic [ARSIZE_WIDTH-1:0]      S_ARSIZE,
   input  logic [ARBURST_WIDTH-1:0]     S_ARBURST,
   input  logic                         S_ARVALID,
   output logic                         S_ARREADY,
   output logic [DATA_WIDTH-1:0]        S_RDATA,
   output logic [RRESP_WIDTH-1:0]       S_RRESP,
   output logic                         S_RLAST,
   output logic                         S_RVALID,
   input  logic                         S_RREADY,
   input  logic                         mem_wr_en,
   input  logic [$clog2(MEM_DEPTH)-1:0] mem_wr_addr,
   input  logic [DATA_WIDTH-1:0]        mem_wr_data
);

   localparam int MW     = $clog2(MEM_DEPTH);
   localparam int SZ_MAX = $clog2(DATA_WIDTH / 8);

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   state_t                   state_q, state_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d, nxt_addr;
   logic [ARLEN_WIDTH-1:0]   len_q, len_d, beat_q, beat_d, beat_nx;
   logic [ARSIZE_WIDTH-1:0]  size_q, size_d;
   logic [ARBURST_WIDTH-1:0] burst_q, burst_d;
   logic                     arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [RRESP_WIDTH-1:0]   rresp_q, rresp_d, ld_resp;
   logic [DATA_WIDTH-1:0]    rdata_q, rdata_d, ld_data;
   logic [ADDR_WIDTH-1:0]    ld_addr, ld_idx;
   logic                     ld_oor;

   axi_rd_addr_gen #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ARLEN_WIDTH(ARLEN_WIDTH),
      .ARSIZE_WIDTH(ARSIZE_WIDTH), .ARBURST_WIDTH(ARBURST_WIDTH)
   ) u_addr_gen (
      .addr(addr_q), .len(len_q), .size(size_q), .burst(burst_q), .next_addr(nxt_addr)
   );

   // Preload port; contents deliberately survive reset.
   always_ff @(posedge ACLK) begin
      if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
   end

   // Address of the beat about to be launched: the AR address for the first
   // beat, the generated next address for the rest.
   assign beat_nx = beat_q + 1'b1;
   assign ld_addr = (state_q == IDLE) ? S_ARADDR : nxt_addr;
   assign ld_idx  = (ld_addr - BASE_ADDR) >> SZ_MAX;
   assign ld_oor  = (ld_idx >= ADDR_WIDTH'(MEM_DEPTH));
   assign ld_data = ld_oor ? '0 : mem[ld_idx[MW-1:0]];

`ifdef AXI_RD_SLV_ERR_EN
   logic [ARBURST_WIDTH-1:0] ld_burst;
   assign ld_burst = (state_q == IDLE) ? S_ARBURST : burst_q;
   assign ld_resp  = (ld_oor || ld_burst == ARBURST_WIDTH'(BURST_RSVD)) ?
                     RRESP_WIDTH'(RESP_SLVERR) : RRESP_WIDTH'(RESP_OKAY);
`else
   assign ld_resp  = RRESP_WIDTH'(RESP_OKAY);
`endif

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      size_d    = size_q;
      burst_d   = burst_q;
      beat_d    = beat_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rlast_d   = rlast_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      case (state_q)
         IDLE: begin
            arready_d = 1'b1;
            if (S_ARVALID && arready_q) begin
               addr_d    = S_ARADDR;
               len_d     = S_ARLEN;
               size_d    = S_ARSIZE;
               burst_d   = S_ARBURST;
               beat_d    = '0;
               arready_d = 1'b0;
               rvalid_d  = 1'b1;
               rdata_d   = ld_data;
               rresp_d   = ld_resp;
               rlast_d   = (S_ARLEN == '0);
               state_d   = BURST;
            end
         end
         BURST: begin
            if (rvalid_q && S_RREADY) begin
               if (rlast_q) begin
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  rresp_d   = RRESP_WIDTH'(RESP_OKAY);
                  arready_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  addr_d  = nxt_addr;
                  beat_d  = beat_nx;
                  rdata_d = ld_data;
                  rresp_d = ld_resp;
                  rlast_d = (beat_nx == len_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         beat_q    <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rresp_q   <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         size_q    <= size_d;
         burst_q   <= burst_d;
         beat_q    <= beat_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
      end
   end

   assign S_ARREADY = arready_q;
   assign S_RVALID  = rvalid_q;
   assign S_RLAST   = rlast_q;
   assign S_RRESP   = rresp_q;
   assign S_RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_read_slave_mem.sv
// Directed bench for axi_read_slave_mem (default parameters).
module tb_axi_read_slave_mem;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic [31:0] S_ARADDR;
   logic [3:0]  S_ARLEN;
   logic [2:0]  S_ARSIZE;
   logic [1:0]  S_ARBURST;
   logic        S_ARVALID;
   logic        S_ARREADY;
   logic [31:0] S_RDATA;
   logic [1:0]  S_RRESP;
   logic        S_RLAST;
   logic        S_RVALID;
   logic        S_RREADY;
   logic        mem_wr_en;
   logic [7:0]  mem_wr_addr;
   logic [31:0] mem_wr_data;

   int vectors = 0;
   int errs    = 0;

`ifdef AXI_RD_SLV_ERR_EN
   localparam logic [1:0] ERR_RESP = 2'b10;
`else
   localparam logic [1:0] ERR_RESP = 2'b00;
`endif

   axi_read_slave_mem dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST),
      .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
      .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST), .S_RVALID(S_RVALID),
      .S_RREADY(S_RREADY),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
   );

   always #5 ACLK = ~ACLK;

   // advance one edge; drive and sample 1 time unit after it
   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // issue an AR; handshake completes on the next edge
   task automatic ar(input string tag, input logic [31:0] a, input logic [3:0] l,
                     input logic [2:0] s, input logic [1:0] b);
      chk({tag, ".arready_pre"}, S_ARREADY, 1);
      S_ARADDR = a; S_ARLEN = l; S_ARSIZE = s; S_ARBURST = b; S_ARVALID = 1'b1;
      step();
      S_ARVALID = 1'b0;
      chk({tag, ".arready_low"}, S_ARREADY, 0);
   endtask

   // check a presented beat and accept it (RREADY assumed high)
   task automatic beat(input string tag, input logic [31:0] d, input logic l, input logic [1:0] r);
      chk({tag, ".rvalid"}, S_RVALID, 1);
      chk({tag, ".rdata"},  S_RDATA,  d);
      chk({tag, ".rlast"},  S_RLAST,  l);
      chk({tag, ".rresp"},  S_RRESP,  r);
      step();
   endtask

   task automatic done(input string tag);
      chk({tag, ".rvalid_end"},  S_RVALID,  0);
      chk({tag, ".arready_end"}, S_ARREADY, 1);
   endtask

   initial begin
      ARESETN = 1'b0; S_ARADDR = '0; S_ARLEN = '0; S_ARSIZE = '0; S_ARBURST = '0;
      S_ARVALID = 1'b0; S_RREADY = 1'b1; mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;
      step(); step();
      chk("rst.arready", S_ARREADY, 0);
      chk("rst.rvalid",  S_RVALID,  0);
      chk("rst.rlast",   S_RLAST,   0);
      chk("rst.rresp",   S_RRESP,   0);
      chk("rst.rdata",   S_RDATA,   0);

      ARESETN = 1'b1;
      step();
      chk("rel.arready", S_ARREADY, 1);

      // preload words 0..15 = A0+i, last word = DEADBEEF
      for (int i = 0; i < 16; i++) begin
         mem_wr_en = 1'b1; mem_wr_addr = 8'(i); mem_wr_data = 32'hA0 + 32'(i);
         step();
      end
      mem_wr_addr = 8'd255; mem_wr_data = 32'hDEADBEEF;
      step();
      mem_wr_en = 1'b0;

      // 1: INCR 4 beats
      ar("incr", 32'h0, 4'd3, 3'd2, 2'b01);
      beat("incr.b0", 32'hA0, 0, 2'b00);
      beat("incr.b1", 32'hA1, 0, 2'b00);
      beat("incr.b2", 32'hA2, 0, 2'b00);
      beat("incr.b3", 32'hA3, 1, 2'b00);
      done("incr");

      // 2: WRAP 4 beats from 0x8 -> words 2,3,0,1
      ar("wrap", 32'h8, 4'd3, 3'd2, 2'b10);
      beat("wrap.b0", 32'hA2, 0, 2'b00);
      beat("wrap.b1", 32'hA3, 0, 2'b00);
      beat("wrap.b2", 32'hA0, 0, 2'b00);
      beat("wrap.b3", 32'hA1, 1, 2'b00);
      done("wrap");

      // FIXED 3 beats at 0x4
      ar("fixed", 32'h4, 4'd2, 3'd2, 2'b00);
      beat("fixed.b0", 32'hA1, 0, 2'b00);
      beat("fixed.b1", 32'hA1, 0, 2'b00);
      beat("fixed.b2", 32'hA1, 1, 2'b00);
      done("fixed");

      // WRAP with len=2 is not a legal wrap length: increments
      ar("wrap3", 32'h8, 4'd2, 3'd2, 2'b10);
      beat("wrap3.b0", 32'hA2, 0, 2'b00);
      beat("wrap3.b1", 32'hA3, 0, 2'b00);
      beat("wrap3.b2", 32'hA4, 1, 2'b00);
      done("wrap3");

      // ARSIZE=3 on a 32-bit bus clamps to 4-byte steps
      ar("clamp", 32'h0, 4'd1, 3'd3, 2'b01);
      beat("clamp.b0", 32'hA0, 0, 2'b00);
      beat("clamp.b1", 32'hA1, 1, 2'b00);
      done("clamp");

      // reserved burst type increments; SLVERR when the error option is built
      ar("rsvd", 32'h0, 4'd1, 3'd2, 2'b11);
      beat("rsvd.b0", 32'hA0, 0, ERR_RESP);
      beat("rsvd.b1", 32'hA1, 1, ERR_RESP);
      done("rsvd");

      // 3: backpressure holds the beat stable
      S_RREADY = 1'b0;
      ar("bp", 32'h10, 4'd1, 3'd2, 2'b01);
      for (int i = 0; i < 3; i++) begin
         chk("bp.hold_rvalid", S_RVALID, 1);
         chk("bp.hold_rdata",  S_RDATA,  32'hA4);
         chk("bp.hold_rlast",  S_RLAST,  0);
         chk("bp.hold_rresp",  S_RRESP,  0);
         step();
      end
      S_RREADY = 1'b1;
      beat("bp.b0", 32'hA4, 0, 2'b00);
      beat("bp.b1", 32'hA5, 1, 2'b00);
      done("bp");

      // 4: run off the end of memory
      ar("oor", 32'h3FC, 4'd1, 3'd2, 2'b01);
      beat("oor.b0", 32'hDEADBEEF, 0, 2'b00);
      beat("oor.b1", 32'h0,        1, ERR_RESP);
      done("oor");

      // 5: reset during beat 2 of a 16-beat burst
      ar("rstmid", 32'h0, 4'd15, 3'd2, 2'b01);
      beat("rstmid.b0", 32'hA0, 0, 2'b00);
      beat("rstmid.b1", 32'hA1, 0, 2'b00);
      chk("rstmid.b2_rdata", S_RDATA, 32'hA2);
      ARESETN = 1'b0;
      #1;
      chk("rstmid.rvalid",  S_RVALID,  0);
      chk("rstmid.arready", S_ARREADY, 0);
      chk("rstmid.rlast",   S_RLAST,   0);
      chk("rstmid.rdata",   S_RDATA,   0);
      step();
      ARESETN = 1'b1;
      step();
      chk("rstmid.rel_arready", S_ARREADY, 1);
      chk("rstmid.rel_rvalid",  S_RVALID,  0);
      ar("post", 32'h4, 4'd1, 3'd2, 2'b01);
      beat("post.b0", 32'hA1, 0, 2'b00);
      beat("post.b1", 32'hA2, 1, 2'b00);
      done("post");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
